hazard_fwd_unit_p: RTL and testbench
====================================

// Module: hazard_fwd_unit_p
// PURPOSE
//   Parametrised forwarding/hazard unit for the pipelined MIPS core, sitting at ID.
//   Generalises bypassing to NUM_FWD downstream stages, with per-consumer readiness
//   rules for load and ALU producers.
//   Adds a sequential scoreboard for a multi-cycle multiply/divide unit (MDU) that
//   stalls dependent instructions and counts stall cycles.
// PARAMETERS
//   AW        5   register address width
//   NUM_FWD   2   forwarding stages; index 0 = EX (nearest), NUM_FWD-1 = farthest
//   LD_RDY_ALU 1  load in stage i stalls an ALU consumer while i < LD_RDY_ALU
//   LD_RDY_BR 2   load in stage i stalls a branch/jalr consumer while i < LD_RDY_BR
//   ALU_RDY_BR 1  ALU result in stage i stalls a branch/jalr consumer while i < ALU_RDY_BR
//   MDU_LAT   4   MDU execute cycles before the writeback pulse (>=1)
//   FW        $clog2(NUM_FWD+1)  forward-select width (derived, localparam)
// PORTS
//   clk           in   1           core clock, rising edge
//   rst_n         in   1           asynchronous reset, active-low
//   fs_regwrite   in   NUM_FWD     stage i writes a register
//   fs_memtoreg   in   NUM_FWD     stage i holds a load
//   fs_writereg   in   NUM_FWD*AW  stage i destination; bits [i*AW +: AW]
//   id_valid      in   1           ID holds a real instruction
//   id_rs,id_rt   in   AW          ID source registers
//   id_use_rs/rt  in   1 each      ID instruction actually reads rs / rt
//   id_branch     in   1           ID instruction resolves in ID (beq/bne/jalr)
//   id_mdu_start  in   1           ID instruction is an MDU op
//   id_mdu_dst    in   AW          MDU destination register
//   fwd_a,fwd_b   out  FW          0 = regfile, k = forward from stage k-1
//   stall         out  1           hold PC/IF/ID this cycle
//   flush_ex      out  1           insert bubble into EX (== stall)
//   mdu_busy      out  1           MDU FSM not IDLE
//   mdu_wb        out  1           one-cycle MDU writeback strobe
//   mdu_wb_reg    out  AW          destination accompanying mdu_wb
//   stall_cnt     out  16          saturating count of stall cycles
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, cnt 0, stall_cnt 0, recorded dst 0.
//   Forward (comb): match(i) = fs_regwrite[i] & fs_writereg[i]!=0 & dst==src.
//     fwd_x = i+1 for the lowest matching i, else 0; src $0 always yields 0.
//   Data hazard (comb), per used source and per matching stage i:
//     load & !id_branch & i<LD_RDY_ALU; load & id_branch & i<LD_RDY_BR;
//     !load & id_branch & i<ALU_RDY_BR. Only the lowest matching i is evaluated.
//   MDU FSM: IDLE -> BUSY on id_valid & id_mdu_start & !stall; latch dst, cnt=MDU_LAT-1.
//     BUSY: cnt-- each cycle; at cnt==0 -> WB.
//     WB: mdu_wb=1 and mdu_wb_reg=dst for exactly one cycle; -> IDLE.
//   MDU hazard (comb), asserted while FSM is BUSY or WB:
//     id_valid & (id_mdu_start | used src==dst with dst!=0).
//     A dependent consumer issues the cycle after WB.
//   stall = id_valid & (data hazard | MDU hazard); flush_ex = stall.
//     id_valid=0 forces stall=0; fwd outputs still computed.
//   A start seen while stall=1 is not accepted and is retried on a later cycle.
//   stall_cnt increments on every stall cycle and saturates at 16'hFFFF.
//   Async reset mid-operation: FSM to IDLE, pending MDU op dropped, no mdu_wb.
// TESTING
//   stage0 add $3, ID rs=$3 use_rs -> fwd_a=1, stall=0; ID rs=$0 -> fwd_a=0.
//   stage0 and stage1 both write $5, ID rt=$5 -> fwd_b=1 (nearest wins).
//   Load $4 in stage0, ALU consumer of $4 -> stall 1 cycle.
//     Load in stage1, branch consumer -> stall; load in stage1, ALU consumer -> fwd=2, no stall.
//   MDU start dst=$8 at t0, next ID reads $8 -> stall t1..t4 (MDU_LAT=4).
//     mdu_wb=1 with reg 8 at t4; consumer issues at t5.
//     Independent instructions issue with stall=0.
//   MDU BUSY plus a second MDU start -> stall until the cycle after WB.
//     rst_n low mid-BUSY -> mdu_busy=0 immediately, no mdu_wb, stall_cnt=0.
//   Hold a hazard 70000 cycles -> stall_cnt saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/hazard_fwd_unit_p.sv
// ----------------------------------------------------------------------------
// hazard_fwd_unit_p
// Forwarding and hazard unit for the pipelined MIPS core, evaluated at ID.
// It selects a bypass source for each ID operand from NUM_FWD downstream
// stages. It stalls on operands that are not ready yet, with separate
// readiness rules for load and ALU producers. It also tracks one in-flight
// multi-cycle multiply/divide (MDU) operation and stalls its dependents.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   fs_regwrite/memtoreg     per-stage write-enable / load flags (bit i = stage i)
//   fs_writereg              per-stage destination, stage i at [i*AW +: AW]
//   id_valid                 ID holds a real instruction
//   id_rs/id_rt, id_use_*    ID source registers and whether they are read
//   id_branch                ID instruction resolves in ID (beq/bne/jalr)
//   id_mdu_start/id_mdu_dst  ID instruction is an MDU op, and its destination
//   fwd_a/fwd_b              0 = register file, k = forward from stage k-1
//   stall/flush_ex           hold PC/IF/ID and bubble EX this cycle
//   mdu_busy                 MDU tracker not idle
//   mdu_wb/mdu_wb_reg        one-cycle MDU writeback strobe and its destination
//   stall_cnt                saturating count of stall cycles
// ----------------------------------------------------------------------------
module hazard_fwd_unit_p #(
  parameter int AW         = 5,
  parameter int NUM_FWD    = 2,
  parameter int LD_RDY_ALU = 1,
  parameter int LD_RDY_BR  = 2,
  parameter int ALU_RDY_BR = 1,
  parameter int MDU_LAT    = 4,
  localparam int FW        = $clog2(NUM_FWD + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FWD-1:0]    fs_regwrite,
  input  logic [NUM_FWD-1:0]    fs_memtoreg,
  input  logic [NUM_FWD*AW-1:0] fs_writereg,
  input  logic                  id_valid,
  input  logic [AW-1:0]         id_rs,
  input  logic [AW-1:0]         id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_branch,
  input  logic                  id_mdu_start,
  input  logic [AW-1:0]         id_mdu_dst,
  output logic [FW-1:0]         fwd_a,
  output logic [FW-1:0]         fwd_b,
  output logic                  stall,
  output logic                  flush_ex,
  output logic                  mdu_busy,
  output logic                  mdu_wb,
  output logic [AW-1:0]         mdu_wb_reg,
  output logic [15:0]           stall_cnt
);

  // Counter only has to hold MDU_LAT-1; keep at least one bit.
  localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } mdu_state_t;

  mdu_state_t          r_state;
  logic [CW-1:0]       r_cnt;
  logic [AW-1:0]       r_dst;
  logic                r_mdu_busy;
  logic                r_mdu_wb;
  logic [AW-1:0]       r_mdu_wb_reg;
  logic [15:0]         r_stall_cnt;

  logic [NUM_FWD-1:0]  w_match_a;
  logic [NUM_FWD-1:0]  w_match_b;
  logic [NUM_FWD-1:0]  w_stage_haz;
  logic [FW-1:0]       w_fwd_a;
  logic [FW-1:0]       w_fwd_b;
  logic                w_haz_a;
  logic                w_haz_b;
  logic                w_mdu_active;
  logic                w_mdu_dep;
  logic                w_mdu_haz;
  logic                w_stall;

  // Per-stage operand matches and whether that stage's result is still too young.
  always_comb begin
    w_match_a   = {NUM_FWD{1'b0}};
    w_match_b   = {NUM_FWD{1'b0}};
    w_stage_haz = {NUM_FWD{1'b0}};
    for (int i = 0; i < NUM_FWD; i++) begin
      // A zero destination never matches, so $0 always reads the register file.
      w_match_a[i] = fs_regwrite[i] & (fs_writereg[i*AW +: AW] != {AW{1'b0}})
                     & (fs_writereg[i*AW +: AW] == id_rs);
      w_match_b[i] = fs_regwrite[i] & (fs_writereg[i*AW +: AW] != {AW{1'b0}})
                     & (fs_writereg[i*AW +: AW] == id_rt);
      if (fs_memtoreg[i]) begin
        w_stage_haz[i] = id_branch ? (i < LD_RDY_BR) : (i < LD_RDY_ALU);
      end else begin
        w_stage_haz[i] = id_branch & (i < ALU_RDY_BR);
      end
    end
  end

  // Nearest matching stage wins: walk from farthest to nearest so the last hit sticks.
  always_comb begin
    w_fwd_a = {FW{1'b0}};
    w_fwd_b = {FW{1'b0}};
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_match_a[i]) begin
        w_fwd_a = FW'(i + 1);
        w_haz_a = w_stage_haz[i];
      end else begin
        w_fwd_a = w_fwd_a;
      end
      if (w_match_b[i]) begin
        w_fwd_b = FW'(i + 1);
        w_haz_b = w_stage_haz[i];
      end else begin
        w_fwd_b = w_fwd_b;
      end
    end
  end

  // MDU hazard: any new MDU op, or a reader of the pending destination, waits out BUSY and WB.
  always_comb begin
    w_mdu_active = (r_state != S_IDLE);
    w_mdu_dep    = (r_dst != {AW{1'b0}})
                   & ((id_use_rs & (id_rs == r_dst)) | (id_use_rt & (id_rt == r_dst)));
    w_mdu_haz    = w_mdu_active & (id_mdu_start | w_mdu_dep);
    w_stall      = id_valid & ((w_haz_a & id_use_rs) | (w_haz_b & id_use_rt) | w_mdu_haz);
  end

  // MDU tracker: writeback strobe lands MDU_LAT cycles after the start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CW{1'b0}};
      r_dst        <= {AW{1'b0}};
      r_mdu_busy   <= 1'b0;
      r_mdu_wb     <= 1'b0;
      r_mdu_wb_reg <= {AW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          // A start held off by a stall is not taken; ID presents it again later.
          if (id_valid & id_mdu_start & ~w_stall) begin
            r_dst      <= id_mdu_dst;
            r_mdu_busy <= 1'b1;
            if (MDU_LAT == 1) begin
              r_state      <= S_WB;
              r_cnt        <= {CW{1'b0}};
              r_mdu_wb     <= 1'b1;
              r_mdu_wb_reg <= id_mdu_dst;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CW'(MDU_LAT - 1);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          // Leave when the count would reach zero so WB falls exactly MDU_LAT cycles in.
          if (r_cnt == CW'(1'b1)) begin
            r_state      <= S_WB;
            r_cnt        <= {CW{1'b0}};
            r_mdu_wb     <= 1'b1;
            r_mdu_wb_reg <= r_dst;
          end else begin
            r_cnt <= r_cnt - CW'(1'b1);
          end
        end
        S_WB: begin
          r_state      <= S_IDLE;
          r_mdu_busy   <= 1'b0;
          r_mdu_wb     <= 1'b0;
          r_mdu_wb_reg <= {AW{1'b0}};
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= {CW{1'b0}};
          r_mdu_busy   <= 1'b0;
          r_mdu_wb     <= 1'b0;
          r_mdu_wb_reg <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign fwd_a      = w_fwd_a;
  assign fwd_b      = w_fwd_b;
  assign stall      = w_stall;
  assign flush_ex   = w_stall;
  assign mdu_busy   = r_mdu_busy;
  assign mdu_wb     = r_mdu_wb;
  assign mdu_wb_reg = r_mdu_wb_reg;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit_p.sv
// Bench for hazard_fwd_unit_p: directed vector table, hand-written MDU
// sequences, randomized cycles against a readiness/timeline reference model,
// and stall-counter saturation.
module tb_hazard_fwd_unit_p;
  localparam int AW  = 5;
  localparam int NF  = 2;
  localparam int LRA = 1;
  localparam int LRB = 2;
  localparam int ARB = 1;
  localparam int LAT = 4;
  localparam int FW  = $clog2(NF + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic [NF-1:0]    fs_regwrite, fs_memtoreg;
  logic [NF*AW-1:0] fs_writereg;
  logic id_valid, id_use_rs, id_use_rt, id_branch, id_mdu_start;
  logic [AW-1:0] id_rs, id_rt, id_mdu_dst;
  logic [FW-1:0] fwd_a, fwd_b;
  logic stall, flush_ex, mdu_busy, mdu_wb;
  logic [AW-1:0] mdu_wb_reg;
  logic [15:0] stall_cnt;

  hazard_fwd_unit_p #(.AW(AW), .NUM_FWD(NF), .LD_RDY_ALU(LRA), .LD_RDY_BR(LRB),
                      .ALU_RDY_BR(ARB), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .fs_regwrite(fs_regwrite), .fs_memtoreg(fs_memtoreg),
    .fs_writereg(fs_writereg), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .id_mdu_start(id_mdu_start), .id_mdu_dst(id_mdu_dst), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .flush_ex(flush_ex), .mdu_busy(mdu_busy), .mdu_wb(mdu_wb),
    .mdu_wb_reg(mdu_wb_reg), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycle index, cycle the MDU op was accepted, its destination,
  // and the number of stall cycles so far.
  int cyc    = 0;
  int st_cyc = -1000;
  logic [AW-1:0] m_dst = '0;
  int m_cnt  = 0;
  logic e_stall;
  logic e_active;

  typedef struct {
    logic [NF-1:0]    rw;
    logic [NF-1:0]    mr;
    logic [NF*AW-1:0] wr;
    logic             v;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic             urs;
    logic             urt;
    logic             br;
    logic [FW-1:0]    ea;
    logic [FW-1:0]    eb;
    logic             es;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Nearest stage that writes src, as 1-based stage number; 0 if none.
  function automatic int ref_src_stage(input logic [AW-1:0] src);
    int hit = 0;
    for (int i = NF - 1; i >= 0; i--)
      if (fs_regwrite[i] && fs_writereg[i*AW +: AW] != 0 && fs_writereg[i*AW +: AW] == src)
        hit = i + 1;
    return hit;
  endfunction

  // An operand is ready once its producer has reached the stage the consumer kind needs.
  function automatic bit ref_haz(input logic [AW-1:0] src, input logic use_s);
    int s = ref_src_stage(src);
    int need;
    if (!use_s || s == 0) return 1'b0;
    if (fs_memtoreg[s-1]) need = id_branch ? LRB : LRA;
    else                  need = id_branch ? ARB : 0;
    return (s - 1) < need;
  endfunction

  task automatic set_idle();
    fs_regwrite = '0; fs_memtoreg = '0; fs_writereg = '0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch = 1'b0; id_mdu_start = 1'b0; id_mdu_dst = '0;
  endtask

  // Sample away from the rising edge and compare every output with the model.
  task automatic apply_check();
    bit busy_c, wb_c, mhaz;
    @(negedge clk);
    busy_c   = (cyc > st_cyc) && (cyc <= st_cyc + LAT);
    wb_c     = (cyc == st_cyc + LAT);
    e_active = busy_c;
    mhaz = busy_c && (id_mdu_start || (m_dst != 0 &&
           ((id_use_rs && id_rs == m_dst) || (id_use_rt && id_rt == m_dst))));
    e_stall = id_valid && (ref_haz(id_rs, id_use_rs) || ref_haz(id_rt, id_use_rt) || mhaz);
    check("fwd_a", fwd_a, ref_src_stage(id_rs));
    check("fwd_b", fwd_b, ref_src_stage(id_rt));
    check("stall", stall, e_stall);
    check("flush_ex", flush_ex, e_stall);
    check("mdu_busy", mdu_busy, busy_c);
    check("mdu_wb", mdu_wb, wb_c);
    check("mdu_wb_reg", mdu_wb_reg, wb_c ? m_dst : 5'd0);
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_stall && m_cnt < 65535) m_cnt++;
    if (id_valid && id_mdu_start && !e_stall && !e_active) begin
      st_cyc = cyc;
      m_dst  = id_mdu_dst;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mdu_busy", mdu_busy, 0);
    check("rst_mdu_wb", mdu_wb, 0);
    check("rst_wb_reg", mdu_wb_reg, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    st_cyc = -1000;
    m_dst  = '0;
    m_cnt  = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // {rw, mr, wr{s1,s0}, valid, rs, rt, use_rs, use_rt, branch, fwd_a, fwd_b, stall}
    vecs[0]  = '{2'b01, 2'b00, {5'd0, 5'd3}, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, {5'd0, 5'd3}, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[2]  = '{2'b11, 2'b00, {5'd5, 5'd5}, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0};
    vecs[3]  = '{2'b01, 2'b01, {5'd0, 5'd4}, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1};
    vecs[4]  = '{2'b10, 2'b10, {5'd4, 5'd0}, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1};
    vecs[5]  = '{2'b10, 2'b10, {5'd4, 5'd0}, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    vecs[6]  = '{2'b01, 2'b00, {5'd0, 5'd6}, 1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 1'b1};
    vecs[7]  = '{2'b10, 2'b00, {5'd6, 5'd0}, 1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
    vecs[8]  = '{2'b01, 2'b01, {5'd0, 5'd4}, 1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
    vecs[9]  = '{2'b01, 2'b01, {5'd0, 5'd4}, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
    vecs[10] = '{2'b00, 2'b00, {5'd9, 5'd9}, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[11] = '{2'b01, 2'b00, {5'd0, 5'd0}, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
    vecs[12] = '{2'b11, 2'b01, {5'd7, 5'd7}, 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1};

    set_idle();
    do_reset();

    // Directed vector table (MDU idle).
    for (int k = 0; k < 13; k++) begin
      fs_regwrite = vecs[k].rw; fs_memtoreg = vecs[k].mr; fs_writereg = vecs[k].wr;
      id_valid = vecs[k].v; id_rs = vecs[k].rs; id_rt = vecs[k].rt;
      id_use_rs = vecs[k].urs; id_use_rt = vecs[k].urt; id_branch = vecs[k].br;
      apply_check();
      check($sformatf("vec%0d_fwd_a", k), fwd_a, vecs[k].ea);
      check($sformatf("vec%0d_fwd_b", k), fwd_b, vecs[k].eb);
      check($sformatf("vec%0d_stall", k), stall, vecs[k].es);
      tick();
    end

    // MDU start dst=$8 at t0, dependent reader stalls t1..t4, WB at t4, issues t5.
    set_idle();
    id_valid = 1'b1; id_mdu_start = 1'b1; id_mdu_dst = 5'd8; id_rs = 5'd1; id_use_rs = 1'b1;
    apply_check(); check("mdu_t0_stall", stall, 0); tick();
    id_mdu_start = 1'b0; id_rs = 5'd8;
    for (int k = 1; k <= 4; k++) begin
      apply_check();
      check("mdu_dep_stall", stall, 1);
      check("mdu_dep_wb", mdu_wb, (k == 4) ? 1 : 0);
      if (k == 4) check("mdu_dep_wb_reg", mdu_wb_reg, 8);
      tick();
    end
    apply_check(); check("mdu_dep_issue", stall, 0); check("mdu_idle_after", mdu_busy, 0); tick();

    // Independent instruction issues while the MDU is busy.
    id_mdu_start = 1'b1; id_mdu_dst = 5'd9; id_rs = 5'd2;
    apply_check(); tick();
    id_mdu_start = 1'b0; id_rs = 5'd2; id_rt = 5'd3; id_use_rt = 1'b1;
    apply_check(); check("indep_stall", stall, 0); check("indep_busy", mdu_busy, 1); tick();
    set_idle();
    for (int k = 0; k < 4; k++) begin apply_check(); tick(); end

    // Second MDU start while busy waits until the cycle after WB.
    id_valid = 1'b1; id_mdu_start = 1'b1; id_mdu_dst = 5'd10;
    apply_check(); tick();
    id_mdu_dst = 5'd11;
    for (int k = 1; k <= 4; k++) begin apply_check(); check("mdu2_stall", stall, 1); tick(); end
    apply_check(); check("mdu2_accept", stall, 0); tick();
    set_idle();
    apply_check(); check("mdu2_busy", mdu_busy, 1); tick();

    // Reset in the middle of BUSY: op dropped, no writeback afterwards.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply_check(); check("post_rst_no_wb", mdu_wb, 0); tick();
    end

    // Randomized cycles against the model.
    for (int k = 0; k < 400; k++) begin
      fs_regwrite  = NF'($urandom_range(0, 3));
      fs_memtoreg  = fs_regwrite & NF'($urandom_range(0, 3));
      fs_writereg  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      id_branch    = ($urandom_range(0, 9) < 3);
      id_mdu_start = ($urandom_range(0, 9) < 2);
      id_mdu_dst   = 5'($urandom_range(0, 7));
      apply_check();
      tick();
    end

    // Hold a load-use hazard long enough to saturate the stall counter.
    set_idle();
    do_reset();
    fs_regwrite = 2'b01; fs_memtoreg = 2'b01; fs_writereg = {5'd0, 5'd4};
    id_valid = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1;
    apply_check();
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk);
      if (m_cnt < 65535) m_cnt++;
      cyc++;
    end
    #1;
    apply_check(); check("sat_cnt", stall_cnt, 16'hFFFF); tick();
    apply_check(); check("sat_no_wrap", stall_cnt, 16'hFFFF); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
